// File: rtl/uart_wishbone_bridge.sv
// Host command bridge: framed UART bytes in, Wishbone classic single cycles out.
// Frames are CMD LEN A3..A0 [data words]; read data is returned MSB first.
module uart_wishbone_bridge #(
    parameter int ADDR_WIDTH = 30,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [31:0]           wb_dat_w,
    output logic [3:0]            wb_sel,
    input  logic [31:0]           wb_dat_r,
    input  logic                  wb_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_SEND
    } state_t;

    localparam logic [31:0] TO_LIM = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic        cmd_wr;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] tcnt;
    logic [23:0] rd_sh;
    logic        cyc_q;

    logic rx_acc;
    logic tx_acc;
    logic ack;
    logic parsing;
    logic timeout;
    logic last_byte;

    assign rx_acc    = rx_valid && rx_ready;
    assign tx_acc    = tx_valid && tx_ready;
    assign ack       = cyc_q && wb_ack;
    assign last_byte = (byte_cnt == 2'd3);
    assign parsing   = (state == S_LEN) || (state == S_ADDR) || (state == S_WDATA);
    // An accepted byte in the limit cycle takes precedence over the abort.
    assign timeout   = (TIMEOUT != 0) && parsing && !rx_acc && (tcnt == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (rx_acc && (rx_data == 8'h01 || rx_data == 8'h02)) state_nx = S_LEN;
            end
            S_LEN: begin
                if (rx_acc) state_nx = (rx_data == 8'h00) ? S_IDLE : S_ADDR;
                else if (timeout) state_nx = S_IDLE;
            end
            S_ADDR: begin
                if (rx_acc && last_byte) state_nx = cmd_wr ? S_WDATA : S_WB_RD;
                else if (timeout) state_nx = S_IDLE;
            end
            S_WDATA: begin
                if (rx_acc && last_byte) state_nx = S_WB_WR;
                else if (timeout) state_nx = S_IDLE;
            end
            S_WB_WR: begin
                if (ack) state_nx = (word_cnt != 8'd1) ? S_WDATA : S_IDLE;
            end
            S_WB_RD: begin
                if (ack) state_nx = S_SEND;
            end
            S_SEND: begin
                if (tx_acc && last_byte) state_nx = (word_cnt != 8'd0) ? S_WB_RD : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = parsing || (state == S_IDLE);
        tx_valid = (state == S_SEND);
        wb_cyc   = cyc_q;
        wb_stb   = cyc_q;
        wb_we    = cyc_q && (state == S_WB_WR);
        wb_sel   = cyc_q ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr   <= 1'b0;
            word_cnt <= 8'd0;
            byte_cnt <= 2'd0;
            wb_adr   <= '0;
            wb_dat_w <= 32'd0;
            cyc_q    <= 1'b0;
            rd_sh    <= 24'd0;
            tx_data  <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    byte_cnt <= 2'd0;
                    if (rx_acc) cmd_wr <= (rx_data == 8'h01);
                end
                S_LEN: begin
                    if (rx_acc) word_cnt <= rx_data;
                end
                S_ADDR: begin
                    if (rx_acc) begin
                        wb_adr   <= ADDR_WIDTH'({wb_adr, rx_data});
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_acc) begin
                        wb_dat_w <= {wb_dat_w[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WB_WR, S_WB_RD: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                    end else if (wb_ack) begin
                        cyc_q    <= 1'b0;
                        wb_adr   <= wb_adr + ADDR_WIDTH'(1);
                        word_cnt <= word_cnt - 8'd1;
                        if (state == S_WB_RD) begin
                            tx_data <= wb_dat_r[31:24];
                            rd_sh   <= wb_dat_r[23:0];
                        end
                    end
                end
                S_SEND: begin
                    if (tx_acc) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        tx_data  <= rd_sh[23:16];
                        rd_sh    <= {rd_sh[15:0], 8'h00};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= 32'd0;
        end else if (TIMEOUT == 0 || !parsing || rx_acc || timeout) begin
            tcnt <= 32'd0;
        end else begin
            tcnt <= tcnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Randomized bench for uart_wishbone_bridge: frame-level model predicts
// bus transactions and TX bytes; one negedge monitor compares them.
module tb_uart_wishbone_bridge;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat_w;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_r = 32'd0;
    logic          wb_ack = 1'b0;

    always #5 clk = ~clk;

    uart_wishbone_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [31:0]   dat;
    } bus_t;

    int checks = 0;
    int errors = 0;

    bus_t          exp_bus[$];
    logic [7:0]    exp_tx[$];
    logic [7:0]    obs_tx[$];
    logic [AW-1:0] obs_adr[$];
    logic [31:0]   obs_dat[$];
    logic [31:0]   frame_words[$];

    int bus_count    = 0;
    int ack_fix      = -1;
    bit hold_ack     = 1'b0;
    bit tx_rand      = 1'b0;
    int long_gap_idx = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == AW'(32'h0400_0000)) return 32'hDEAD_BEEF;
        if (a == AW'(32'h0400_0001)) return 32'h0102_0304;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Slave, interface sanity and TX sink, all sampled on the falling edge.
    int   wcnt = 0;
    int   dly = 0;
    bit   stall = 1'b0;
    logic [7:0] stall_data = 8'd0;
    bus_t se;

    always @(negedge clk) begin
        if (rst) begin
            wb_ack = 1'b0;
            wcnt = 0;
            tx_ready = 1'b0;
            stall = 1'b0;
        end else begin
            if (wb_cyc && wb_stb && !hold_ack && !wb_ack) begin
                if (wcnt >= dly) begin
                    wb_ack = 1'b1;
                    wb_dat_r = mem_word(wb_adr);
                    bus_count++;
                    obs_adr.push_back(wb_adr);
                    obs_dat.push_back(wb_dat_w);
                    if (exp_bus.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bus: adr %h we %b", wb_adr, wb_we);
                    end else begin
                        se = exp_bus.pop_front();
                        chk("wb_adr", 32'(wb_adr), 32'(se.adr));
                        chk("wb_we", 32'(wb_we), 32'(se.we));
                        if (se.we) chk("wb_dat_w", wb_dat_w, se.dat);
                        chk("wb_sel_cycle", 32'(wb_sel), 32'hF);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wb_ack = 1'b0;
                wb_dat_r = $urandom;
                wcnt = 0;
                dly = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
            end

            chk("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
            chk("sel", 32'(wb_sel), wb_cyc ? 32'hF : 32'h0);
            if (!wb_cyc) chk("we_idle", 32'(wb_we), 32'd0);

            if (stall) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            tx_ready = tx_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tx_valid && tx_ready) begin
                obs_tx.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: byte %h", tx_data);
                end else begin
                    chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
                stall = 1'b0;
            end else begin
                stall = tx_valid;
                stall_data = tx_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL rx_stuck: byte %h never accepted", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
    endtask

    // Model a whole frame, then send it byte by byte.
    task automatic run_frame(input logic [7:0] cmd, input int len, input logic [31:0] addr);
        logic [7:0] q[$];
        bus_t e;
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            e.adr = addr[AW-1:0] + AW'(i);
            e.we = (cmd == 8'h01);
            e.dat = e.we ? frame_words[i] : 32'd0;
            exp_bus.push_back(e);
            if (!e.we) begin
                d = mem_word(e.adr);
                for (int k = 3; k >= 0; k--) exp_tx.push_back(d[k*8 +: 8]);
            end
        end
        q.push_back(cmd);
        q.push_back(8'(len));
        for (int k = 3; k >= 0; k--) q.push_back(addr[k*8 +: 8]);
        if (cmd == 8'h01) begin
            for (int i = 0; i < len; i++) begin
                d = frame_words[i];
                for (int k = 3; k >= 0; k--) q.push_back(d[k*8 +: 8]);
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            send_byte(q[k], (k == long_gap_idx) ? 90 : int'($urandom_range(0, 3)));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || wb_cyc || tx_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 5000), 32'd1);
        exp_bus.delete();
        exp_tx.delete();
        @(negedge clk);
        chk("rx_ready_idle", 32'(rx_ready), 32'd1);
    endtask

    task automatic check_rst();
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'd0);
        chk("rst_dat_w", wb_dat_w, 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
    endtask

    task automatic fill_words(input int len);
        frame_words.delete();
        for (int i = 0; i < len; i++) frame_words.push_back($urandom);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit[8];
        int cnt0;
        int n;
        logic [31:0] a;
        int len;
        logic [7:0] cmd;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_rst();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_rst();

        // Single write, fixed 2-cycle ack latency.
        ack_fix = 2;
        obs_tx.delete(); obs_adr.delete(); obs_dat.delete();
        cnt0 = bus_count;
        frame_words.delete();
        frame_words.push_back(32'h1234_5678);
        run_frame(8'h01, 1, 32'h0400_0000);
        wait_idle("drain_write");
        chk("write_count", 32'(bus_count - cnt0), 32'd1);
        chk("write_adr_lit", (obs_adr.size() > 0) ? 32'(obs_adr[0]) : 32'hX, 32'h0400_0000);
        chk("write_dat_lit", (obs_dat.size() > 0) ? obs_dat[0] : 32'hX, 32'h1234_5678);
        chk("write_no_tx", 32'(obs_tx.size()), 32'd0);

        // Burst read with random ack latency.
        ack_fix = -1;
        obs_tx.delete(); obs_adr.delete();
        run_frame(8'h02, 2, 32'h0400_0000);
        wait_idle("drain_burst");
        lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        chk("burst_tx_n", 32'(obs_tx.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_tx.size()) chk("burst_tx_lit", 32'(obs_tx[i]), 32'(lit[i]));
        end
        chk("burst_adr0", (obs_adr.size() > 0) ? 32'(obs_adr[0]) : 32'hX, 32'h0400_0000);
        chk("burst_adr1", (obs_adr.size() > 1) ? 32'(obs_adr[1]) : 32'hX, 32'h0400_0001);

        // Garbage and LEN=0 produce no bus traffic.
        cnt0 = bus_count;
        send_byte(8'h55, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h01, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 1);
        repeat (20) @(negedge clk);
        chk("garbage_no_bus", 32'(bus_count - cnt0), 32'd0);
        chk("garbage_rx_ready", 32'(rx_ready), 32'd1);
        fill_words(1);
        run_frame(8'h01, 1, 32'hC000_0ABC);
        wait_idle("drain_after_garbage");

        // Partial frame times out; next frame parses from scratch.
        cnt0 = bus_count;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        repeat (150) @(negedge clk);
        chk("timeout_no_bus", 32'(bus_count - cnt0), 32'd0);
        chk("timeout_rx_ready", 32'(rx_ready), 32'd1);
        fill_words(1);
        run_frame(8'h01, 1, 32'h0000_0123);
        wait_idle("drain_after_timeout");
        chk("timeout_next_count", 32'(bus_count - cnt0), 32'd1);

        // A gap just under the limit must not abort the frame.
        cnt0 = bus_count;
        long_gap_idx = 3;
        fill_words(2);
        run_frame(8'h01, 2, 32'h0000_0200);
        long_gap_idx = -1;
        wait_idle("drain_long_gap");
        chk("long_gap_count", 32'(bus_count - cnt0), 32'd2);

        // Address wrap with TX backpressure.
        tx_rand = 1'b1;
        obs_adr.delete();
        run_frame(8'h02, 2, 32'h3FFF_FFFF);
        wait_idle("drain_wrap");
        chk("wrap_adr0", (obs_adr.size() > 0) ? 32'(obs_adr[0]) : 32'hX, 32'h3FFF_FFFF);
        chk("wrap_adr1", (obs_adr.size() > 1) ? 32'(obs_adr[1]) : 32'hX, 32'h0000_0000);
        tx_rand = 1'b0;

        // Reset while the slave withholds ack.
        hold_ack = 1'b1;
        run_frame(8'h02, 1, 32'h0000_0010);
        n = 0;
        while (!wb_cyc && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_cyc_seen", 32'(wb_cyc), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("async_stb_drop", 32'(wb_stb), 32'd0);
        chk("async_tx_valid", 32'(tx_valid), 32'd0);
        exp_bus.delete();
        exp_tx.delete();
        hold_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_rst();
        fill_words(1);
        run_frame(8'h01, 1, 32'h0000_0777);
        wait_idle("drain_after_reset");

        // Random mixed traffic.
        for (int f = 0; f < 25; f++) begin
            tx_rand = ($urandom_range(0, 1) == 1);
            cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
            len = int'($urandom_range(1, 3));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31:30], 30'h3FFF_FFFF} - 32'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(3, 255)), 0);
            fill_words(len);
            run_frame(cmd, len, a);
            wait_idle("drain_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_wishbone_bridge.md
Name: uart_wishbone_bridge

Overview:
Command decoder between the UART byte receiver/transmitter and the SoC Wishbone bus; gives the host (simulation bench or PC tool) register/memory access over the serial link.
Parses framed byte commands from the RX byte stream and issues classic Wishbone single cycles.
Streams read data back to the TX byte stream, big-endian.

Parameters:
ADDR_WIDTH, 30, Wishbone word-address width; host address bytes are truncated to the low ADDR_WIDTH bits.
TIMEOUT, 1000000, clk cycles allowed between accepted bytes of one frame before the parser aborts; 0 disables.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  bridge accepts byte (transfer when rx_valid & rx_ready)
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  write enable
wb_adr  out  ADDR_WIDTH  word address
wb_dat_w  out  32  write data
wb_sel  out  4  byte selects, always 4'hF during a cycle
wb_dat_r  in  32  read data
wb_ack  in  1  acknowledge

Behaviour:
- Reset (async, one clk is sufficient): state IDLE, rx_ready=1, tx_valid=0, tx_data=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0, all counters 0.
- Frame format: CMD, LEN, A3, A2, A1, A0 (32-bit word address, MSB first), then for writes LEN×4 data bytes, MSB first per word.
- CMD 0x01 = write; CMD 0x02 = read.
- Address increments by 1 per word, modulo 2^ADDR_WIDTH (wraps to 0).
- States: IDLE, LEN, ADDR, WDATA, WB_WR, WB_RD, SEND.
- IDLE: on a byte transfer, 0x01 or 0x02 latches cmd and goes to LEN; any other byte is discarded and the state stays IDLE.
- LEN: latches word_cnt. LEN=0 returns to IDLE with no bus activity.
- ADDR: collects 4 bytes via a 2-bit byte_cnt.
  - After the 4th byte, a write goes to WDATA and a read goes to WB_RD.
- WDATA: collects 4 bytes into wb_dat_w, then goes to WB_WR.
- WB_WR / WB_RD:
  - cyc, stb and we (WB_WR only) are asserted starting the cycle after state entry.
  - They are held until wb_ack is sampled high, then deasserted on the next edge.
  - Each cycle issues exactly one ack'd transfer; there is no bus timeout.
  - On ack in WB_RD, wb_dat_r is latched into a shift register and the state goes to SEND.
  - After each word: word_cnt decrements and address increments. Next state:
    - write: WDATA if word_cnt≠0, else IDLE.
    - read: SEND.
- SEND:
  - Presents the 4 bytes MSB first; tx_valid stays high until tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - After the 4th byte: WB_RD if word_cnt≠0, else IDLE.
- rx_ready: 1 in IDLE, LEN, ADDR, WDATA; 0 in WB_WR, WB_RD, SEND.
  - Bytes arriving while rx_ready=0 are held off by the upstream FIFO and are not lost by the bridge.
- Timeout (TIMEOUT≠0): counter runs in LEN, ADDR and WDATA.
  - It clears on every accepted byte.
  - On reaching TIMEOUT it forces IDLE and discards the partial frame; no bus cycle is issued for a partial word.
  - The counter does not run in WB_* or SEND.
- Simultaneous events: a byte accepted in the same cycle the timeout is reached wins; the byte is taken and the counter clears.
- Reset mid-operation: wb_cyc and wb_stb drop immediately (async), tx_valid drops, and the partial frame is lost.

Test Plan:
- Write: bytes 01 01 04 00 00 00 12 34 56 78, ack 2 cycles after stb -> exactly one cycle with adr=0x04000000, we=1, sel=F, dat_w=0x12345678; no TX bytes; rx_ready returns to 1.
- Burst read: 02 02 04 00 00 00, slave returns 0xDEADBEEF then 0x01020304 with 0–3 cycle ack delays -> TX emits DE AD BE EF 01 02 03 04; adr goes 0x04000000 then 0x04000001.
- Garbage/LEN=0: 55 FF, then 01 00 00 00 00 00 -> no bus cycle; a following valid write frame executes normally.
- Timeout: TIMEOUT=100, send 01 01 04 then stall 150 cycles -> parser in IDLE, no bus cycle; the next full frame executes correctly.
- TX backpressure/wrap: read LEN=2 at 0x3FFFFFFF with tx_ready toggling randomly -> addresses 0x3FFFFFFF then 0x00000000; tx_data stable while stalled; byte order correct.
- Reset mid-cycle: assert rst while wb_cyc=1 and the slave withholds ack -> cyc/stb low immediately; after release all outputs hold reset values and a new frame works.
